// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART RX: oversampled frame FSM, valid/ready holding register, error pulses
// Optional parity check (PARITY state, parity_err port) enabled by defining UART_PARITY_EN.
`timescale 1ns/1ps
module uart_receiver #(
   parameter int DataBits   = 8,
   parameter int Oversample = 16,
   parameter int ParityOdd  = 0
) (
   input  logic                g_clk,
   input  logic                rst_n,
   input  logic                r_clk,
   input  logic                rx,
   output logic [DataBits-1:0] rx_data,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                busy,
   output logic                frame_err,
   output logic                overrun_err
`ifdef UART_PARITY_EN
   ,
   output logic                parity_err
`endif
);
   localparam int CW = $clog2(Oversample);
   localparam int IW = $clog2(DataBits);
   localparam logic [CW-1:0] CntMid  = CW'(Oversample / 2 - 1);
   localparam logic [CW-1:0] CntLast = CW'(Oversample - 1);
   localparam logic [IW-1:0] IdxLast = IW'(DataBits - 1);

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t              state, state_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic [IW-1:0]       idx, idx_d;
   logic [DataBits-1:0] shift, shift_d;
   logic                rx_m, rx_s;
   logic                frame_done;
   logic                good;
`ifdef UART_PARITY_EN
   logic                par_bit, par_bit_d;
   logic                par_bad;
`endif

   always_ff @(posedge g_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m  <= 1'b1;
         rx_s  <= 1'b1;
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
`ifdef UART_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         rx_m  <= rx;
         rx_s  <= rx_m;
         state <= state_d;
         cnt   <= cnt_d;
         idx   <= idx_d;
         shift <= shift_d;
`ifdef UART_PARITY_EN
         par_bit <= par_bit_d;
`endif
      end
   end

   // Everything in here only moves on oversample ticks.
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      idx_d      = idx;
      shift_d    = shift;
      frame_done = 1'b0;
`ifdef UART_PARITY_EN
      par_bit_d  = par_bit;
`endif
      if (r_clk) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  cnt_d   = '0;
               end
            end
            START: begin
               cnt_d = cnt + 1'b1;
               if (cnt == CntMid) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               cnt_d = cnt + 1'b1;
               if (cnt == CntLast) begin
                  cnt_d        = '0;
                  shift_d[idx] = rx_s;
                  idx_d        = idx + 1'b1;
                  if (idx == IdxLast) begin
                     idx_d = '0;
`ifdef UART_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               cnt_d = cnt + 1'b1;
               if (cnt == CntLast) begin
                  cnt_d     = '0;
                  par_bit_d = rx_s;
                  state_d   = STOP;
               end
            end
`endif
            STOP: begin
               cnt_d = cnt + 1'b1;
               if (cnt == CntLast) begin
                  cnt_d      = '0;
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

`ifdef UART_PARITY_EN
   assign par_bad = ((^shift) ^ (ParityOdd != 0)) != par_bit;
   assign good    = frame_done && rx_s && !par_bad;
`else
   assign good    = frame_done && rx_s;
`endif

   always_ff @(posedge g_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         frame_err   <= frame_done && !rx_s;
         overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
         parity_err  <= frame_done && par_bad;
`endif
         // A same-cycle consume frees the register for the incoming word.
         if (good) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver (r_clk every 4 g_clk, 16x oversample)
`timescale 1ns/1ps
module tb_uart_receiver;
   localparam int K_WORD = 0;
   localparam int K_FERR = 1;
   localparam int K_OVR  = 2;
   localparam int K_PERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   logic       g_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       r_clk = 1'b0;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_err;
   logic       overrun_err;
`ifdef UART_PARITY_EN
   logic       parity_err;
`endif

   int   n_checks = 0;
   int   n_fail = 0;
   exp_t exp_q[$];

   uart_receiver #(.DataBits(8), .Oversample(16), .ParityOdd(0)) dut (
      .g_clk(g_clk),
      .rst_n(rst_n),
      .r_clk(r_clk),
      .rx(rx),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .busy(busy),
      .frame_err(frame_err),
      .overrun_err(overrun_err)
`ifdef UART_PARITY_EN
      ,
      .parity_err(parity_err)
`endif
   );

   always #5 g_clk = ~g_clk;

   initial begin
      forever begin
         repeat (3) @(posedge g_clk);
         #1 r_clk = 1'b1;
         @(posedge g_clk);
         #1 r_clk = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input logic [7:0] data);
      exp_t e;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind, input logic [7:0] data);
      exp_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_event", {kind[15:0], 8'h00, data}, 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("scoreboard", {kind[15:0], 8'h00, data}, {e.kind[15:0], 8'h00, e.data});
      end
   endtask

   // Monitor: every error pulse cycle and every newly presented word is one event.
   initial begin
      logic       pv;
      logic [7:0] pd;
      pv = 1'b0;
      pd = 8'h00;
      forever begin
         @(negedge g_clk);
         if (!rst_n) begin
            pv = 1'b0;
            pd = 8'h00;
         end else begin
            if (frame_err) pop_cmp(K_FERR, 8'h00);
`ifdef UART_PARITY_EN
            if (parity_err) pop_cmp(K_PERR, 8'h00);
`endif
            if (overrun_err) pop_cmp(K_OVR, 8'h00);
            if (rx_valid && (!pv || rx_data != pd)) pop_cmp(K_WORD, rx_data);
            pv = rx_valid;
            pd = rx_data;
         end
      end
   end

   task automatic wait_tick();
      do @(posedge g_clk); while (r_clk !== 1'b1);
   endtask

   task automatic send_bit(input logic v);
      #1 rx = v;
      repeat (16) wait_tick();
   endtask

   // Stop bit is sampled on its 9th tick; ready_end raises rx_ready for exactly that cycle.
   task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                             input bit chk_lat, input bit ready_end);
      wait_tick();
      send_bit(1'b0);
      for (int k = 0; k < 8; k++) send_bit(data[k]);
`ifdef UART_PARITY_EN
      send_bit(par);
`else
      if (par === 1'bx) $display("note: parity unused");
`endif
      #1 rx = stop;
      repeat (8) wait_tick();
      repeat (3) @(posedge g_clk);
      #1;
      if (chk_lat) check("latency_before_stop", {31'd0, rx_valid}, 32'd0);
      if (ready_end) rx_ready = 1'b1;
      @(posedge g_clk);
      #1 rx_ready = 1'b0;
      if (chk_lat) begin
         check("latency_valid", {31'd0, rx_valid}, 32'd1);
         check("latency_data", {24'd0, rx_data}, {24'd0, data});
      end
      repeat (7) wait_tick();
      #1 rx = 1'b1;
      repeat (8) wait_tick();
   endtask

   task automatic consume();
      @(posedge g_clk);
      #1 rx_ready = 1'b1;
      @(posedge g_clk);
      #1 rx_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
      check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_overrun_err"}, {31'd0, overrun_err}, 32'd0);
   endtask

   initial begin
      logic [7:0] v5a;
      v5a = 8'h5A;
      repeat (3) @(posedge g_clk);
      #2 check_all_zero("reset");
      @(posedge g_clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge g_clk);

      // Basic receive, rx_ready low, one cycle latency after stop sample
      expect_evt(K_WORD, 8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
      consume();

      // Short low glitch is rejected as a false start
      wait_tick();
      #1 rx = 1'b0;
      repeat (5) wait_tick();
      #1 rx = 1'b1;
      check("glitch_busy_high", {31'd0, busy}, 32'd1);
      repeat (16) wait_tick();
      #1;
      check("glitch_busy_low", {31'd0, busy}, 32'd0);
      check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);

      // Bad stop bit
      expect_evt(K_FERR, 8'h00);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);

      // Overrun: second word lost, first kept
      expect_evt(K_WORD, 8'h11);
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_evt(K_OVR, 8'h00);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
      check("overrun_keeps_old", {24'd0, rx_data}, 32'h11);
      consume();
      check("overrun_consumed", {31'd0, rx_valid}, 32'd0);

      // Consume in the same cycle the next word lands: no overrun
      expect_evt(K_WORD, 8'h11);
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_evt(K_WORD, 8'h22);
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
      check("simul_data", {24'd0, rx_data}, 32'h22);
      check("simul_valid", {31'd0, rx_valid}, 32'd1);

`ifdef UART_PARITY_EN
      consume();
      expect_evt(K_PERR, 8'h00);
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
      check("perr_no_valid", {31'd0, rx_valid}, 32'd0);
      expect_evt(K_WORD, 8'h07);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
      check("parity_good_data", {24'd0, rx_data}, 32'h07);
`endif

      // Reset during data bit 4 (a word is still held), then a clean frame
      wait_tick();
      send_bit(1'b0);
      for (int k = 0; k < 4; k++) send_bit(v5a[k]);
      #1 rx = v5a[4];
      repeat (8) wait_tick();
      #1 rst_n = 1'b0;
      #2 check_all_zero("midframe_reset");
      repeat (3) @(posedge g_clk);
      #1 rx = 1'b1;
      repeat (2) @(posedge g_clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge g_clk);
      expect_evt(K_WORD, 8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      check("after_reset_data", {24'd0, rx_data}, 32'h5A);

      repeat (20) @(posedge g_clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
